// File: rtl/mario_render_pkg.sv
// Shared constants and types for the Mario render path (World, sprite renderer, pixel mux).
package mario_render_pkg;

    localparam int SCREEN_W  = 640;
    localparam int SCREEN_H  = 480;
    localparam int SPR_W     = 16;
    localparam int SPR_H     = 16;

    localparam int MIRROR_BIT = 5;
    localparam int FRAME_MSB  = 4;

    localparam int SPR_XB = $clog2(SPR_W);
    localparam int SPR_YB = $clog2(SPR_H);
    // ROM address layout is {frame, row, col}
    localparam int ROM_AW = FRAME_MSB + 1 + SPR_YB + SPR_XB;

    typedef logic [11:0] rgb444_t;

    localparam rgb444_t TRANSPARENT = 12'hF0F;
    localparam rgb444_t DBG_COLOR   = 12'hF00;

endpackage

// File: rtl/mario_sprite_render_if.sv
// Pixel query / result bus between the VGA scan pipeline and the sprite renderer.
interface mario_sprite_render_if;
    import mario_render_pkg::*;

    // Valid-only stream with no ready: the renderer accepts a query on every
    // cycle pix_valid is high, and out_valid follows pix_valid exactly 3 cycles later.
    logic        pix_valid;
    logic [10:0] pix_x;
    logic [9:0]  pix_y;
    logic        out_valid;
    logic        out_hit;
    rgb444_t     out_rgb;

    modport master (
        output pix_valid, pix_x, pix_y,
        input  out_valid, out_hit, out_rgb
    );

    modport slave (
        input  pix_valid, pix_x, pix_y,
        output out_valid, out_hit, out_rgb
    );

endinterface

// File: rtl/mario_sprite_addr_gen.sv
// Combinational sprite-relative offset, in-box test and sprite ROM address for one query.
// With MARIO_HITBOX_DEBUG_EN defined it also flags the hitbox outline pixels.
module mario_sprite_addr_gen
    import mario_render_pkg::*;
(
    input  logic [10:0]        pix_x,
    input  logic [9:0]         pix_y,
    input  logic signed [12:0] scr_x,
    input  logic [9:0]         spr_y,
    input  logic               visible,
    input  logic [5:0]         id,
    output logic               in_box,
`ifdef MARIO_HITBOX_DEBUG_EN
    output logic               edge_px,
`endif
    output logic [ROM_AW-1:0]  addr
);

    localparam logic signed [13:0] SPR_W_S  = 14'(SPR_W);
    localparam logic signed [10:0] SPR_H_S  = 11'(SPR_H);
    localparam logic [10:0]        SCR_W_U  = 11'(SCREEN_W);
    localparam logic [9:0]         SCR_H_U  = 10'(SCREEN_H);
    localparam logic [SPR_XB-1:0]  COL_MAX  = SPR_XB'(SPR_W - 1);
    localparam logic [SPR_YB-1:0]  ROW_MAX  = SPR_YB'(SPR_H - 1);

    logic signed [13:0] dx;
    logic signed [10:0] dy;
    logic [SPR_XB-1:0]  col;
    logic [SPR_YB-1:0]  row;

    always_comb begin
        // dx needs 14 bits: pix_x up to 2047 minus scr_x down to -4095
        dx = $signed({3'b000, pix_x}) - $signed({scr_x[12], scr_x});
        dy = $signed({1'b0, pix_y}) - $signed({1'b0, spr_y});

        in_box = visible
              && (dx >= 14'sd0) && (dx < SPR_W_S)
              && (dy >= 11'sd0) && (dy < SPR_H_S)
              && (pix_x < SCR_W_U) && (pix_y < SCR_H_U);

        col = id[MIRROR_BIT] ? (COL_MAX - dx[SPR_XB-1:0]) : dx[SPR_XB-1:0];
        row = dy[SPR_YB-1:0];
        addr = {id[FRAME_MSB:0], row, col};
`ifdef MARIO_HITBOX_DEBUG_EN
        edge_px = (dx[SPR_XB-1:0] == '0) || (dx[SPR_XB-1:0] == COL_MAX)
               || (dy[SPR_YB-1:0] == '0) || (dy[SPR_YB-1:0] == ROW_MAX);
`endif
    end

endmodule

// File: rtl/mario_sprite_render.sv
// Mario sprite renderer: per-frame shadow of player state, 3-stage pixel query pipeline
// around a synchronous sprite ROM. Optional hitbox outline via MARIO_HITBOX_DEBUG_EN.
module mario_sprite_render
    import mario_render_pkg::*;
#(
    parameter int VIEW_W = 33
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 frame_start,
    input  logic [10:0]          mario_x,
    input  logic [9:0]           mario_y,
    input  logic [5:0]           mario_id,
    input  logic [VIEW_W-1:0]    view,
    mario_sprite_render_if.slave pix,
    output logic [ROM_AW-1:0]    rom_addr,
    input  rgb444_t              rom_data
);

    localparam logic signed [12:0] VIS_LO = 13'(-SPR_W);
    localparam logic signed [12:0] VIS_HI = 13'(SCREEN_W);

    logic [10:0]        sh_x;
    logic [9:0]         sh_y;
    logic [5:0]         sh_id;
    logic [11:0]        sh_view;
    logic signed [12:0] scr_x;
    logic               visible;

    logic               ag_in_box;
    logic [ROM_AW-1:0]  ag_addr;
    logic               s1_v, s1_in_box;
    logic               s2_v, s2_in_box;
    logic               s3_hit;
    rgb444_t            s3_rgb;

    // The camera only ever moves within a 4096-pixel window of the player
    logic unused_view_hi;
    assign unused_view_hi = ^view[VIEW_W-1:12];

    always_comb begin
        scr_x   = $signed({2'b00, sh_x}) - $signed({1'b0, sh_view});
        visible = !rst && (scr_x > VIS_LO) && (scr_x < VIS_HI);
    end

`ifdef MARIO_HITBOX_DEBUG_EN
    logic ag_edge, s1_edge, s2_edge;
`endif

    mario_sprite_addr_gen u_addr_gen (
        .pix_x   (pix.pix_x),
        .pix_y   (pix.pix_y),
        .scr_x   (scr_x),
        .spr_y   (sh_y),
        .visible (visible),
        .id      (sh_id),
        .in_box  (ag_in_box),
`ifdef MARIO_HITBOX_DEBUG_EN
        .edge_px (ag_edge),
`endif
        .addr    (ag_addr)
    );

    always_comb begin
        s3_hit = s2_in_box && (rom_data != TRANSPARENT);
        s3_rgb = s3_hit ? rom_data : '0;
`ifdef MARIO_HITBOX_DEBUG_EN
        if (s2_in_box && s2_edge) begin
            s3_hit = 1'b1;
            s3_rgb = DBG_COLOR;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sh_x          <= '0;
            sh_y          <= '0;
            sh_id         <= '0;
            sh_view       <= '0;
            s1_v          <= 1'b0;
            s1_in_box     <= 1'b0;
            rom_addr      <= '0;
            s2_v          <= 1'b0;
            s2_in_box     <= 1'b0;
            pix.out_valid <= 1'b0;
            pix.out_hit   <= 1'b0;
            pix.out_rgb   <= '0;
        end else begin
            // A query in the frame_start cycle still sees the previous shadow
            if (frame_start) begin
                sh_x    <= mario_x;
                sh_y    <= mario_y;
                sh_id   <= mario_id;
                sh_view <= view[11:0];
            end
            s1_v      <= pix.pix_valid;
            s1_in_box <= pix.pix_valid && ag_in_box;
            if (pix.pix_valid) rom_addr <= ag_addr;
            s2_v          <= s1_v;
            s2_in_box     <= s1_in_box;
            pix.out_valid <= s2_v;
            pix.out_hit   <= s3_hit;
            pix.out_rgb   <= s3_rgb;
        end
    end

`ifdef MARIO_HITBOX_DEBUG_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_edge <= 1'b0;
            s2_edge <= 1'b0;
        end else begin
            s1_edge <= ag_edge;
            s2_edge <= s1_edge;
        end
    end
`endif

endmodule

// File: doc/mario_sprite_render.md
Name: mario_sprite_render

Overview:
- Consumer of the World block's player-state outputs (mario_x, mario_y, mario_id) and camera offset (view).
- Converts the player's world position into screen space and answers per-pixel "is Mario here, and what colour" queries from the VGA scan pipeline.
- Fetches texels from an external synchronous sprite ROM.
- Sits between World and the pixel mux that composites background, blocks and Mario.

Parameters:
- SCREEN_W, 640, visible width in pixels
- SCREEN_H, 480, visible height in pixels
- SPR_W, 16, sprite width (power of two)
- SPR_H, 16, sprite height (power of two)
- VIEW_W, 33, width of the camera offset input
- TRANSPARENT, 12'hF0F, ROM colour treated as see-through
- DBG_COLOR, 12'hF00, hitbox outline colour (optional feature only)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- frame_start  in  1  one-cycle pulse at start of vertical blank
- mario_x  in  11  player left edge, world coordinates
- mario_y  in  10  player top edge, screen rows
- mario_id  in  6  [5] facing-left (mirror), [4:0] animation frame
- view  in  VIEW_W  camera left edge, world coordinates
- pix_valid  in  1  query valid this cycle
- pix_x  in  11  queried screen column
- pix_y  in  10  queried screen row
- rom_addr  out  13  {frame[4:0], row[3:0], col[3:0]}
- rom_data  in  12  texel RGB444, valid exactly 1 cycle after rom_addr
- out_valid  out  1  result valid
- out_hit  out  1  opaque Mario pixel at queried position
- out_rgb  out  12  colour when out_hit, else 12'h000

Behaviour:
- Reset (synchronous, active-high, priority over all other inputs) clears to 0: out_valid, out_hit, out_rgb, rom_addr, all pipeline valid bits, and the shadow registers.
- While in reset, the visible flag is 0, so no hits are produced.
- Shadow snapshot:
  - On a frame_start cycle, latch mario_x, mario_y, mario_id and the low 12 bits of view.
  - All queries use only the shadow values; mid-frame input changes must not tear the sprite.
- Screen X:
  - scr_x = shadow_mario_x − shadow_view, computed 13-bit signed.
  - visible = scr_x > −SPR_W and scr_x < SCREEN_W; partial left/right clipping is allowed.
- Pipeline: 3 stages; out_valid = pix_valid delayed exactly 3 cycles.
  - S1 registers dx = pix_x − scr_x and dy = pix_y − shadow_y (signed), plus in_box = visible and 0 ≤ dx < SPR_W and 0 ≤ dy < SPR_H.
  - S2 drives rom_addr. col = dx[3:0], or SPR_W−1−dx[3:0] when id[5] is set. row = dy[3:0]. rom_addr is held when the S1 valid bit is low.
  - S3 samples rom_data and sets out_hit = in_box and rom_data ≠ TRANSPARENT. out_rgb = rom_data if out_hit, else 0.
- Query handling:
  - No back-pressure: one query is accepted every cycle.
  - Queries with pix_valid low create bubbles (out_valid low 3 cycles later) and never produce a hit.
- Boundaries:
  - pix_x ≥ SCREEN_W or pix_y ≥ SCREEN_H gives out_hit = 0.
  - frame_start coincident with pix_valid: the query in that cycle still uses the old shadow; the new shadow applies from the next cycle.
  - Reset mid-pipeline: in-flight results are dropped, out_valid = 0 for the 3 cycles after reset deasserts while the pipeline refills.
- Width rules: pix_x wraps are not possible (11-bit range exceeds SCREEN_W). view bits above bit 11 are ignored.

Optional Feature:
- Macro: MARIO_HITBOX_DEBUG_EN.
- When defined: pixels with in_box where dx ∈ {0, SPR_W−1} or dy ∈ {0, SPR_H−1} force out_hit = 1 and out_rgb = DBG_COLOR, overriding transparency. Latency is unchanged.
- When undefined: the outline logic is absent and behaviour is exactly as above.

Decomposition:
- Package mario_render_pkg holds SCREEN_W, SCREEN_H, SPR_W, SPR_H, TRANSPARENT, the RGB444 type, and the mario_id field positions (MIRROR_BIT = 5, FRAME_MSB = 4). World and the pixel mux import it too.
- One sub-module, mario_sprite_addr_gen: combinational dx/dy/in_box/mirror/address generation, registered by the parent in S1/S2.

Test Plan:
- Reset/idle: rst high 4 cycles with pix_valid = 1 → out_valid = 0, out_hit = 0, out_rgb = 0 throughout, and for the 3 cycles after release.
- Basic hit: frame_start with mario_x = 700, view = 640, mario_y = 400, id = 6'd2. Query (60,400) → rom_addr = {5'd2, 4'd0, 4'd0}; 3 cycles later out_hit = 1 and out_rgb = rom_data when ROM returns 12'h0A5. The same query with ROM returning 12'hF0F → out_hit = 0.
- Mirror: id = 6'b100010, query (61,405) → rom_addr col = 14, row = 5.
- Clipping: mario_x = 630, view = 640 (scr_x = −10). Query (5,400) → in_box, col = 15. Query (6,400) → out_hit = 0. mario_x = 1300 → no hits anywhere.
- Snapshot: change mario_x mid-frame from 700 to 720 without frame_start → hits still at columns 60..75; after the next frame_start → hits at columns 80..95.
- Throughput: 100 back-to-back queries with every 7th pix_valid low → out_valid pattern is identical, delayed 3 cycles, with no drops.
